// File: rtl/log_event_serializer.sv
// Log event serializer: severity filter, cycle timestamp, record FIFO and
// 9-byte framer (sync, level, src, code, ts) onto a valid/ready byte stream.
module log_event_serializer #(
   parameter string      NAME      = "log_event_serializer",
   parameter int         DEPTH     = 8,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic [2:0]             cfg_min_level,
   input  logic                   evt_valid,
   output logic                   evt_ready,
   input  logic [2:0]             evt_level,
   input  logic [7:0]             evt_src,
   input  logic [15:0]            evt_code,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic [7:0]             tx_data,
   output logic [15:0]            dropped_cnt,
   output logic [$clog2(DEPTH):0] fifo_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int RW = 59;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic {IDLE, SEND} state_e;

   logic [RW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic [31:0]   ts_q;
   logic          evt_ready_q;
   logic [15:0]   drop_q;
   state_e        state_q;
   logic [3:0]    idx_q;
   logic [71:0]   frame_q;
   logic          tx_valid_q;

   logic          accept, pass, push, pop, hs, last;
   logic [RW-1:0] head;
   logic [71:0]   load;

   // cfg values above ERROR (4) reject every level
   assign pass   = (cfg_min_level <= 3'd4) && (evt_level >= cfg_min_level);
   assign accept = evt_valid && evt_ready_q;
   assign push   = accept && pass;
   assign hs     = tx_valid_q && tx_ready;
   assign last   = (idx_q == 4'd8);
   assign pop    = (cnt_q != '0) && ((state_q == IDLE) || (hs && last));
   assign head   = mem_q[rd_ptr_q];
   assign load   = {SYNC_BYTE, 5'b0, head};

   always_comb begin
      cnt_d = cnt_q;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (push) mem_q[wr_ptr_q] <= {evt_level, evt_src, evt_code, ts_q};
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         ts_q        <= '0;
         evt_ready_q <= 1'b0;
         drop_q      <= '0;
         state_q     <= IDLE;
         idx_q       <= '0;
         frame_q     <= '0;
         tx_valid_q  <= 1'b0;
      end else begin
         ts_q        <= ts_q + 32'd1;
         cnt_q       <= cnt_d;
         evt_ready_q <= (cnt_d != FULL);
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (accept && !pass && drop_q != '1) drop_q <= drop_q + 16'd1;
         unique case (state_q)
            IDLE: begin
               if (pop) begin
                  frame_q    <= load;
                  idx_q      <= '0;
                  tx_valid_q <= 1'b1;
                  state_q    <= SEND;
               end
            end
            SEND: begin
               // tx_data is the frame MSB byte; shifting keeps it registered
               if (hs) begin
                  if (!last) begin
                     frame_q <= {frame_q[63:0], 8'h00};
                     idx_q   <= idx_q + 4'd1;
                  end else if (pop) begin
                     frame_q <= load;
                     idx_q   <= '0;
                  end else begin
                     tx_valid_q <= 1'b0;
                     state_q    <= IDLE;
                  end
               end
            end
         endcase
      end
   end

   assign evt_ready   = evt_ready_q;
   assign tx_valid    = tx_valid_q;
   assign tx_data     = frame_q[71:64];
   assign dropped_cnt = drop_q;
   assign fifo_level  = cnt_q;

`ifndef SYNTHESIS
   always @(posedge aclk) begin
      if (aresetn && accept && !pass)
         $display("%s: filtered level %0d src %h code %h",
                  NAME, evt_level, evt_src, evt_code);
   end
`endif

endmodule
